mem_stage: RTL and testbench

Memory-access pipeline stage between `exe_stage` and `wb_stage`. It accepts the execute-stage bus and waits for the data-SRAM `data_ok` of each load or store the execute stage has issued. It aligns and sign- or zero-extends load data, and passes the result with a per-byte register write strobe to writeback. It buffers early-arriving read data while writeback stalls, discards responses that belong to flushed instructions, and drives the MEM forwarding bus.

---
 rtl/mem_stage_if.sv | 12 +
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: valid/allowin/bus handshake between two adjacent pipeline stages.
// The producing stage uses the master modport and the consuming stage uses slave.
interface mem_stage_if #(
    parameter int WIDTH = 131
);
    logic             valid;
    logic             allowin;
    logic [WIDTH-1:0] bus;

    modport master (output valid, output bus, input allowin);
    modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. It waits for data-SRAM responses, aligns load data and feeds WB.
// Define MS_FWD_EN to forward the MEM-stage result on ms_fwd_bus; otherwise decode stalls on MEM hazards.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  es_ms,
    mem_stage_if.master ms_ws,
    input  logic        es_mem_inflight,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        flush,
    output logic        ms_ex,
    output logic [38:0] ms_fwd_bus
);
    localparam int ES_TO_MS_BUS_WD = 131;
    localparam int MS_TO_WS_BUS_WD = 125;

    typedef struct packed {
        logic lw;
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lwl;
        logic lwr;
    } ld_inst_t;

    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic        store_op;
        logic [31:0] badvaddr;
        logic [10:0] c0_bus;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        ld_inst_t    ld_inst;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic [10:0] c0_bus;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ws_bus_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    logic [ES_TO_MS_BUS_WD-1:0] es_raw;
    logic [MS_TO_WS_BUS_WD-1:0] ws_raw;
    es_bus_t                    es_in;
    es_bus_t                    ms_r;
    ws_bus_t                    ws_out;
    state_t                     state;
    state_t                     state_nxt;
    logic                       ms_valid;
    logic [31:0]                buf_data;
    logic [1:0]                 discard_cnt;
    logic [1:0]                 discard_cnt_nxt;
    logic [2:0]                 outstanding;
    logic                       new_expect;
    logic                       mem_expect;
    logic                       live_ok;
    logic                       ms_ready_go;
    logic                       ms_allowin;
    logic                       accept;
    logic [31:0]                ld_data;
    logic [1:0]                 ld_p;
    logic [7:0]                 ld_byte;
    logic [15:0]                ld_half;
    logic [31:0]                ld_result;
    logic [3:0]                 ld_we;
    logic [31:0]                final_result;
    logic [3:0]                 rf_we;
    logic                       fwd_pending;
    logic [31:0]                fwd_result;

    assign es_raw     = es_ms.bus;
    assign es_in      = es_bus_t'(es_raw);
    assign new_expect = (es_in.res_from_mem || es_in.store_op) && !es_in.ex;

    assign mem_expect  = ms_valid && (ms_r.res_from_mem || ms_r.store_op) && !ms_r.ex;
    assign live_ok     = data_sram_data_ok && (discard_cnt == 2'd0);
    assign ms_ready_go = !mem_expect || live_ok || (state == S_HOLD);
    assign ms_allowin  = !ms_valid || (ms_ready_go && ms_ws.allowin);
    assign accept      = es_ms.valid && ms_allowin && !flush;

    assign es_ms.allowin = ms_allowin;
    assign ms_ws.valid   = ms_valid && ms_ready_go && !flush;
    assign ms_ex         = ms_valid && ms_r.ex;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the entry register is reset along with the flops so that idle outputs read as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            ms_r     <= '0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_ms.valid;
            if (es_ms.valid) ms_r <= es_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            discard_cnt <= 2'd0;
            buf_data    <= 32'd0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_cnt_nxt;
            if (accept)
                buf_data <= 32'd0;
            else if (state == S_WAIT && live_ok && !ms_ws.allowin)
                buf_data <= data_sram_rdata;
        end
    end

    // When ms_allowin is high the current entry (if any) is leaving, so the next
    // state depends only on what is being accepted; WAIT with a response and no
    // allowin can only mean writeback is stalled, which is the HOLD case.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = S_IDLE;
        else if (ms_allowin)
            state_nxt = (es_ms.valid && new_expect) ? S_WAIT : S_IDLE;
        else if (state == S_WAIT && live_ok)
            state_nxt = S_HOLD;
    end

    // Responses still owed to flushed instructions: pending discards, the WAIT
    // entry's own request and the one execute has in flight, less any response
    // arriving in the flush cycle itself.
    always_comb begin
        discard_cnt_nxt = discard_cnt;
        outstanding     = {1'b0, discard_cnt} + {2'b00, state == S_WAIT} + {2'b00, es_mem_inflight};
        if (flush) begin
            if (data_sram_data_ok && outstanding != 3'd0) outstanding = outstanding - 3'd1;
            discard_cnt_nxt = (outstanding > 3'd3) ? 2'd3 : outstanding[1:0];
        end else if (data_sram_data_ok && discard_cnt != 2'd0) begin
            discard_cnt_nxt = discard_cnt - 2'd1;
        end
    end

    assign ld_data = (state == S_HOLD) ? buf_data : data_sram_rdata;
    assign ld_p    = ms_r.res[1:0];
    assign ld_byte = ld_data[{ld_p, 3'b000} +: 8];
    assign ld_half = ld_p[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        ld_result = ld_data;
        ld_we     = 4'b1111;
        if (ms_r.ld_inst.lw) begin
            ld_result = ld_data;
        end else if (ms_r.ld_inst.lb || ms_r.ld_inst.lbu) begin
            ld_result = {{24{ms_r.ld_inst.lb & ld_byte[7]}}, ld_byte};
        end else if (ms_r.ld_inst.lh || ms_r.ld_inst.lhu) begin
            ld_result = {{16{ms_r.ld_inst.lh & ld_half[15]}}, ld_half};
        end else if (ms_r.ld_inst.lwl) begin
            ld_result = ld_data << {~ld_p, 3'b000};
            ld_we     = 4'b1111 << ~ld_p;
        end else if (ms_r.ld_inst.lwr) begin
            ld_result = ld_data >> {ld_p, 3'b000};
            ld_we     = 4'b1111 >> ld_p;
        end
    end

    assign final_result = ms_r.res_from_mem ? ld_result : ms_r.res;
    assign rf_we        = ms_r.ex ? 4'b0000 : (ms_r.res_from_mem ? ld_we : {4{ms_r.gr_we}});

    always_comb begin
        ws_out              = '0;
        ws_out.tlbwi        = ms_r.tlbwi;
        ws_out.tlbr         = ms_r.tlbr;
        ws_out.c0_bus       = ms_r.c0_bus;
        ws_out.bd           = ms_r.bd;
        ws_out.ex           = ms_r.ex;
        ws_out.excode       = ms_r.excode;
        ws_out.badvaddr     = ms_r.badvaddr;
        ws_out.rf_we        = rf_we;
        ws_out.dest         = ms_r.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = ms_r.pc;
    end

    assign ws_raw    = ws_out;
    assign ms_ws.bus = ws_raw;

`ifdef MS_FWD_EN
    assign fwd_pending = mem_expect && !ms_ready_go;
    assign fwd_result  = (ms_valid && ms_ready_go) ? final_result : 32'd0;
`else
    assign fwd_pending = ms_valid && ms_r.gr_we;
    assign fwd_result  = 32'd0;
`endif

    assign ms_fwd_bus = {fwd_pending,
                         ms_valid && ms_r.gr_we && !flush,
                         ms_valid ? ms_r.dest : 5'd0,
                         fwd_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; expected WB results are queued at issue and
// popped when the stage hands an entry to writeback.
module tb_mem_stage;
    localparam logic [6:0] LW  = 7'b1000000;
    localparam logic [6:0] LB  = 7'b0100000;
    localparam logic [6:0] LBU = 7'b0010000;
    localparam logic [6:0] LH  = 7'b0001000;
    localparam logic [6:0] LHU = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;
    localparam logic [6:0] NOL = 7'b0000000;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  we;
        logic        ex;
        logic [31:0] badv;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [6:0]  ld;
        logic [1:0]  p;
        logic [31:0] rd;
        logic [31:0] result;
        logic [3:0]  we;
    } lcase_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_mem_inflight;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        ms_ex;
    logic [38:0] ms_fwd_bus;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    lcase_t      tbl[13];

    mem_stage_if #(.WIDTH(131)) es_ms_if ();
    mem_stage_if #(.WIDTH(125)) ms_ws_if ();

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_ms             (es_ms_if),
        .ms_ws             (ms_ws_if),
        .es_mem_inflight   (es_mem_inflight),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .ms_ex             (ms_ex),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [130:0] mk(input logic [6:0] ld, input logic rfm, input logic st,
                                        input logic gwe, input logic ex,
                                        input logic [31:0] res, input logic [31:0] pc);
        logic [130:0] b;
        b          = '0;
        b[128]     = st;
        b[127:96]  = res;
        b[83]      = ex;
        b[82:78]   = ex ? 5'h05 : 5'h00;
        b[77:71]   = ld;
        b[70]      = rfm;
        b[69]      = gwe;
        b[68:64]   = 5'd7;
        b[63:32]   = res;
        b[31:0]    = pc;
        return b;
    endfunction

    task automatic push(input logic [31:0] result, input logic [3:0] we, input logic ex,
                        input logic [31:0] badv, input logic [31:0] pc);
        exp_t e;
        e.result = result;
        e.we     = we;
        e.ex     = ex;
        e.badv   = badv;
        e.pc     = pc;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [130:0] b);
        es_ms_if.valid = 1'b1;
        es_ms_if.bus   = b;
        #1;
        for (int i = 0; i < 20 && !es_ms_if.allowin; i++) step();
        check("issue_allowin", {31'd0, es_ms_if.allowin}, 32'd1);
        step();
        es_ms_if.valid = 1'b0;
    endtask

    task automatic mem_op(input logic [130:0] b, input logic [31:0] rd, input int delay);
        issue(b);
        for (int i = 0; i < delay; i++) begin
            check("wait_stall", {31'd0, ms_ws_if.valid}, 32'd0);
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        check("resp_valid", {31'd0, ms_ws_if.valid}, 32'd1);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom();
        #1;
        check("one_cycle", {31'd0, ms_ws_if.valid}, 32'd0);
    endtask

    // Writeback side: every transfer pops one expected entry.
    always @(negedge clk) begin
        if (resetn && ms_ws_if.valid && ms_ws_if.allowin) begin
            exp_t e;
            if (sb.size() > 0) begin
                e = sb.pop_front();
            end else begin
                e.result = 32'h0;
                e.we     = 4'h0;
                e.ex     = 1'b0;
                e.badv   = 32'h0;
                e.pc     = 32'hFFFF_FFFC;
            end
            check("wb_pc",     ms_ws_if.bus[31:0],            e.pc);
            check("wb_result", ms_ws_if.bus[63:32],           e.result);
            check("wb_rf_we",  {28'd0, ms_ws_if.bus[72:69]},  {28'd0, e.we});
            check("wb_ex",     {31'd0, ms_ws_if.bus[110]},    {31'd0, e.ex});
            check("wb_badv",   ms_ws_if.bus[104:73],          e.badv);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] pulse_data[3];

        tbl = '{
            '{LB,  2'd2, 32'h12A45678, 32'hFFFFFFA4, 4'b1111},
            '{LWL, 2'd1, 32'hAABBCCDD, 32'hCCDD0000, 4'b1100},
            '{LWR, 2'd2, 32'hAABBCCDD, 32'h0000AABB, 4'b0011},
            '{LB,  2'd1, 32'h12A45678, 32'h00000056, 4'b1111},
            '{LBU, 2'd2, 32'h12A45678, 32'h000000A4, 4'b1111},
            '{LW,  2'd0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111},
            '{LH,  2'd0, 32'h80017FFF, 32'h00007FFF, 4'b1111},
            '{LH,  2'd2, 32'h80017FFF, 32'hFFFF8001, 4'b1111},
            '{LHU, 2'd2, 32'h80017FFF, 32'h00008001, 4'b1111},
            '{LWL, 2'd0, 32'hAABBCCDD, 32'hDD000000, 4'b1000},
            '{LWL, 2'd3, 32'hAABBCCDD, 32'hAABBCCDD, 4'b1111},
            '{LWR, 2'd0, 32'hAABBCCDD, 32'hAABBCCDD, 4'b1111},
            '{LWR, 2'd3, 32'hAABBCCDD, 32'h000000AA, 4'b0001}
        };

        resetn            = 1'b0;
        es_ms_if.valid    = 1'b0;
        es_ms_if.bus      = '0;
        ms_ws_if.allowin  = 1'b1;
        es_mem_inflight   = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        flush             = 1'b0;
        step();
        check("rst_allowin", {31'd0, es_ms_if.allowin}, 32'd1);
        check("rst_valid",   {31'd0, ms_ws_if.valid},   32'd0);
        check("rst_ms_ex",   {31'd0, ms_ex},            32'd0);
        check("rst_fwd_lo",  ms_fwd_bus[31:0],          32'd0);
        check("rst_fwd_hi",  {25'd0, ms_fwd_bus[38:32]}, 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Load alignment table, response 0..2 cycles after entry.
        for (int i = 0; i < 13; i++) begin
            pc   = 32'hBFC0_0000 + 32'(i * 4);
            addr = 32'h0000_1000 | {30'd0, tbl[i].p};
            push(tbl[i].result, tbl[i].we, 1'b0, addr, pc);
            mem_op(mk(tbl[i].ld, 1'b1, 1'b0, 1'b1, 1'b0, addr, pc), tbl[i].rd, i % 3);
        end

        // ALU entry: no response needed, forwarding reflects build option.
        push(32'h1234_5678, 4'b1111, 1'b0, 32'h1234_5678, 32'hBFC0_0100);
        issue(mk(NOL, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'hBFC0_0100));
        check("alu_valid",       {31'd0, ms_ws_if.valid}, 32'd1);
        check("alu_block_valid", {31'd0, ms_fwd_bus[37]}, 32'd1);
        check("alu_fwd_dest",    {27'd0, ms_fwd_bus[36:32]}, 32'd7);
`ifdef MS_FWD_EN
        check("alu_load_pending", {31'd0, ms_fwd_bus[38]}, 32'd0);
        check("alu_fwd_result",   ms_fwd_bus[31:0], 32'h1234_5678);
`else
        check("alu_load_pending", {31'd0, ms_fwd_bus[38]}, 32'd1);
        check("alu_fwd_result",   ms_fwd_bus[31:0], 32'd0);
`endif
        step();

        // Store with AdES: no response expected, rf_we cleared, ms_ex raised.
        push(32'h0000_1003, 4'b0000, 1'b1, 32'h0000_1003, 32'hBFC0_0104);
        issue(mk(NOL, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'hBFC0_0104));
        check("exst_valid", {31'd0, ms_ws_if.valid}, 32'd1);
        check("exst_ms_ex", {31'd0, ms_ex}, 32'd1);
        step();
        check("exst_ms_ex_clr", {31'd0, ms_ex}, 32'd0);

        // ALU entry with exception: write strobe forced off.
        push(32'h0000_0042, 4'b0000, 1'b1, 32'h0000_0042, 32'hBFC0_0108);
        issue(mk(NOL, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'hBFC0_0108));
        step();

        // Normal store: waits for its response, no register write.
        push(32'h0000_2000, 4'b0000, 1'b0, 32'h0000_2000, 32'hBFC0_010C);
        mem_op(mk(NOL, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'hBFC0_010C), 32'h5555_5555, 1);

        // lhu, response three cycles late while writeback is stalled.
        ms_ws_if.allowin = 1'b0;
        push(32'h0000_BEEF, 4'b1111, 1'b0, 32'h0000_3000, 32'hBFC0_0110);
        issue(mk(LHU, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'hBFC0_0110));
        repeat (3) step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_BEEF;
        #1;
        check("hold_resp_valid", {31'd0, ms_ws_if.valid}, 32'd1);
        check("hold_allowin",    {31'd0, es_ms_if.allowin}, 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_0000;
        #1;
        check("hold_valid0", {31'd0, ms_ws_if.valid}, 32'd1);
        step();
        check("hold_valid1", {31'd0, ms_ws_if.valid}, 32'd1);
        ms_ws_if.allowin = 1'b1;
        #1;
        check("hold_release", {31'd0, ms_ws_if.valid}, 32'd1);
        step();
        check("hold_gone", {31'd0, ms_ws_if.valid}, 32'd0);

        // Flush of a ready entry blocks it in the same cycle.
        issue(mk(NOL, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 32'hBFC0_0200));
        flush = 1'b1;
        #1;
        check("flush_blocks", {31'd0, ms_ws_if.valid}, 32'd0);
        step();
        flush = 1'b0;
        check("flush_alu_cnt", {30'd0, dut.discard_cnt}, 32'd0);

        // Flush in WAIT with a request in flight: two responses must be dropped.
        issue(mk(LW, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'hBFC0_0204));
        flush           = 1'b1;
        es_mem_inflight = 1'b1;
        step();
        flush           = 1'b0;
        es_mem_inflight = 1'b0;
        check("flush_cnt", {30'd0, dut.discard_cnt}, 32'd2);
        pulse_data[0] = 32'h1111_1111;
        pulse_data[1] = 32'h2222_2222;
        pulse_data[2] = 32'h3333_3333;
        push(pulse_data[2], 4'b1111, 1'b0, 32'h0000_5000, 32'hBFC0_0208);
        issue(mk(LW, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'hBFC0_0208));
        for (int k = 0; k < 3; k++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = pulse_data[k];
            #1;
            check("discard_pulse", {31'd0, ms_ws_if.valid}, (k == 2) ? 32'd1 : 32'd0);
            step();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'd0;
            if (k < 2) step();
        end

        // Asynchronous reset in WAIT; a stale response afterwards is ignored.
        issue(mk(LW, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_6000, 32'hBFC0_0300));
        check("pre_rst_allowin", {31'd0, es_ms_if.allowin}, 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_allowin", {31'd0, es_ms_if.allowin}, 32'd1);
        check("arst_valid",   {31'd0, ms_ws_if.valid},   32'd0);
        check("arst_ms_ex",   {31'd0, ms_ex},            32'd0);
        check("arst_fwd_lo",  ms_fwd_bus[31:0],          32'd0);
        check("arst_fwd_hi",  {25'd0, ms_fwd_bus[38:32]}, 32'd0);
        step();
        resetn = 1'b1;
        step();
        check("post_rst_allowin", {31'd0, es_ms_if.allowin}, 32'd1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h9999_9999;
        #1;
        check("stale_resp", {31'd0, ms_ws_if.valid}, 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
